// File: rtl/filter_pkg.sv
// Shared constants and types for the spatial-filter pipeline.
package filter_pkg;
  localparam int WIN_PIX = 9;
  localparam int PIX_W   = 8;

  typedef enum logic {IDLE, READ} state_e;

  // Byte slot of row r (0 = top), column c (0 = left) inside a 3x3 window word.
  function automatic int win_byte(input int r, input int c);
    return r * 3 + c;
  endfunction
endpackage

// File: rtl/line_buffer.sv
// One line of pixel storage: single write port, combinational 3-pixel read.
module line_buffer
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  localparam int AW = $clog2(IMG_WIDTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [PIX_W-1:0]   wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [3*PIX_W-1:0] rdata_o
);
  logic [PIX_W-1:0] mem_q [IMG_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Leftmost pixel lands in the low byte.
  for (genvar c = 0; c < 3; c++) begin : g_col
    assign rdata_o[c*PIX_W +: PIX_W] = mem_q[raddr_i + AW'(c)];
  end
endmodule

// File: rtl/window_generator.sv
// Four rotating line buffers feeding a registered 3x3 window stream.
module window_generator
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH = 512
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [PIX_W-1:0]         i_pixel_data,
  input  logic                     i_pixel_data_valid,
  output logic [WIN_PIX*PIX_W-1:0] o_pixel_data,
  output logic                     o_pixel_data_valid,
  output logic                     o_intr,
  output logic                     o_overflow
);
  localparam int AW    = $clog2(IMG_WIDTH);
  localparam int FW    = $clog2(4 * IMG_WIDTH + 1);
  localparam int ROW_W = 3 * PIX_W;
  localparam logic [FW-1:0] FULL_CNT  = FW'(4 * IMG_WIDTH);
  localparam logic [FW-1:0] START_CNT = FW'(3 * IMG_WIDTH);
  localparam logic [FW-1:0] LINE_CNT  = FW'(IMG_WIDTH);
  localparam logic [AW-1:0] LAST_WR_X = AW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] LAST_RD_X = AW'(IMG_WIDTH - 3);

  state_e                     state_q, state_d;
  logic [1:0]                 wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [AW-1:0]              wr_x_q, wr_x_d, rd_x_q, rd_x_d;
  logic [FW-1:0]              fill_cnt_q, fill_cnt_d;
  logic [WIN_PIX*PIX_W-1:0]   pix_q, pix_d, window;
  logic                       valid_q, valid_d, intr_q, intr_d, ovf_q, ovf_d;
  logic                       accept, release_line;
  logic [3:0][ROW_W-1:0]      lb_rdata;

  assign accept = i_pixel_data_valid && (fill_cnt_q != FULL_CNT);

  for (genvar b = 0; b < 4; b++) begin : g_lb
    line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb (
      .clk_i   (i_clk),
      .we_i    (accept && (wr_sel_q == 2'(b))),
      .waddr_i (wr_x_q),
      .wdata_i (i_pixel_data),
      .raddr_i (rd_x_q),
      .rdata_o (lb_rdata[b])
    );
  end

  // Row r comes from buffer rd_sel+r; the 2-bit index wraps 3 -> 0.
  always_comb begin
    window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        window[win_byte(r, c)*PIX_W +: PIX_W] = lb_rdata[2'(rd_sel_q + 2'(r))][c*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_x_d       = rd_x_q;
    rd_sel_d     = rd_sel_q;
    pix_d        = pix_q;
    valid_d      = 1'b0;
    intr_d       = 1'b0;
    release_line = 1'b0;
    wr_x_d       = wr_x_q;
    wr_sel_d     = wr_sel_q;
    ovf_d        = ovf_q | (i_pixel_data_valid && (fill_cnt_q == FULL_CNT));

    case (state_q)
      IDLE: begin
        if (fill_cnt_q >= START_CNT) begin
          state_d = READ;
          rd_x_d  = '0;
        end
      end
      READ: begin
        pix_d   = window;
        valid_d = 1'b1;
        rd_x_d  = rd_x_q + AW'(1);
        if (rd_x_q == LAST_RD_X) begin
          state_d      = IDLE;
          rd_sel_d     = rd_sel_q + 2'd1;
          release_line = 1'b1;
          intr_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (wr_x_q == LAST_WR_X) begin
        wr_x_d   = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_x_d = wr_x_q + AW'(1);
      end
    end

    fill_cnt_d = fill_cnt_q + FW'(accept) - (release_line ? LINE_CNT : FW'(0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      wr_sel_q   <= '0;
      wr_x_q     <= '0;
      rd_sel_q   <= '0;
      rd_x_q     <= '0;
      fill_cnt_q <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      intr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      wr_x_q     <= wr_x_d;
      rd_sel_q   <= rd_sel_d;
      rd_x_q     <= rd_x_d;
      fill_cnt_q <= fill_cnt_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      intr_q     <= intr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = valid_q;
  assign o_intr             = intr_q;
  assign o_overflow         = ovf_q;
endmodule
